// File: rtl/tap_param_if.sv
// Pin and chain-side signals of the parameterised TAP controller.
// TCK, TRST and the tri-state TDO pin stay as plain ports on the controller.
interface tap_param_if #(
  parameter int NUM_CHAINS = 2
);
  logic                  TMS;
  logic                  TDI;
  logic                  TDO_en;
  logic                  test_mode;
  logic [NUM_CHAINS-1:0] chain_tdo;
  logic [NUM_CHAINS-1:0] chain_sel;
  logic                  capturedr;
  logic                  shiftdr;
  logic                  updatedr;

  modport master (
    output TMS, TDI, chain_tdo,
    input  TDO_en, test_mode, chain_sel, capturedr, shiftdr, updatedr
  );

  modport slave (
    input  TMS, TDI, chain_tdo,
    output TDO_en, test_mode, chain_sel, capturedr, shiftdr, updatedr
  );
endinterface

// File: rtl/tap_param.sv
// IEEE 1149.1 TAP controller with IR, IDCODE, BYPASS and NUM_CHAINS external scan chains.
// state    | meaning
// S_TLR    | test-logic-reset, shadow forced to IDCODE
// S_RTI    | run-test/idle
// S_*_DR   | select/capture/shift/exit1/pause/exit2/update of the data register path
// S_*_IR   | same sequence for the instruction register
module tap_param #(
  parameter int          IR_LEN     = 4,
  parameter int          NUM_CHAINS = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic         TCK,
  input  logic         TRST,
  output logic         TDO,
  tap_param_if.slave   bus
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
  } state_t;

  localparam logic [IR_LEN-1:0] OP_IDCODE  = {{(IR_LEN-1){1'b1}}, 1'b0};
  localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

  function automatic state_t next_state(input state_t s, input logic tms);
    case (s)
      S_TLR:    return tms ? S_TLR    : S_RTI;
      S_RTI:    return tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: return tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: return tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  return tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: return tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: return tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: return tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: return tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: return tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: return tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  return tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: return tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: return tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: return tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: return tms ? S_SEL_DR : S_RTI;
      default:  return S_TLR;
    endcase
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic                r_cap_dr, r_sh_dr, r_upd_dr;
  logic                r_cap_ir, r_sh_ir, r_upd_ir;
  logic                r_test_mode;
  logic [IR_LEN-1:0]   r_ir;
  logic [IR_LEN-1:0]   r_ir_sh;
  logic                r_byp;
  logic [31:0]         r_id;
  logic [NUM_CHAINS-1:0] w_chain_sel;
  logic                w_chain_tdo;
  logic                w_chain_act;
  logic                w_sel_id;
  logic                w_sel_byp;
  logic                w_dr_tdo;
  logic                w_tdo;

  assign w_next = next_state(r_state, bus.TMS);

  // State decodes are registered from the next state so they line up with r_state.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_state     <= S_TLR;
      r_cap_dr    <= 1'b0;
      r_sh_dr     <= 1'b0;
      r_upd_dr    <= 1'b0;
      r_cap_ir    <= 1'b0;
      r_sh_ir     <= 1'b0;
      r_upd_ir    <= 1'b0;
      r_test_mode <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cap_dr    <= (w_next == S_CAP_DR);
      r_sh_dr     <= (w_next == S_SH_DR);
      r_upd_dr    <= (w_next == S_UPD_DR);
      r_cap_ir    <= (w_next == S_CAP_IR);
      r_sh_ir     <= (w_next == S_SH_IR);
      r_upd_ir    <= (w_next == S_UPD_IR);
      r_test_mode <= (w_next != S_TLR);
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_ir    <= OP_IDCODE;
      r_ir_sh <= '0;
      r_byp   <= 1'b0;
      r_id    <= '0;
    end else begin
      if (r_cap_ir)
        r_ir_sh <= IR_CAPTURE;
      else if (r_sh_ir)
        r_ir_sh <= {bus.TDI, r_ir_sh[IR_LEN-1:1]};

      if (w_next == S_TLR)
        r_ir <= OP_IDCODE;
      else if (r_upd_ir)
        r_ir <= r_ir_sh;

      if (w_sel_byp) begin
        if (r_cap_dr)
          r_byp <= 1'b0;
        else if (r_sh_dr)
          r_byp <= bus.TDI;
      end

      if (w_sel_id) begin
        if (r_cap_dr)
          r_id <= IDCODE_VAL;
        else if (r_sh_dr)
          r_id <= {bus.TDI, r_id[31:1]};
      end
    end
  end

  // Decode works off the shadow only, so a new instruction lands after Upd-IR.
  always_comb begin
    w_chain_sel = '0;
    w_chain_tdo = 1'b0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      if (r_ir == IR_LEN'(k)) begin
        w_chain_sel[k] = 1'b1;
        w_chain_tdo    = bus.chain_tdo[k];
      end
    end
  end

  assign w_chain_act = |w_chain_sel;
  assign w_sel_id    = (r_ir == OP_IDCODE);
  assign w_sel_byp   = !w_chain_act && !w_sel_id;
  assign w_dr_tdo    = w_chain_act ? w_chain_tdo : (w_sel_id ? r_id[0] : r_byp);
  assign w_tdo       = r_sh_ir ? r_ir_sh[0] : w_dr_tdo;

  assign bus.TDO_en    = r_sh_dr | r_sh_ir;
  assign TDO           = bus.TDO_en ? w_tdo : 1'bz;
  assign bus.test_mode = r_test_mode;
  assign bus.chain_sel = w_chain_sel;
  assign bus.capturedr = r_cap_dr & w_chain_act;
  assign bus.shiftdr   = r_sh_dr  & w_chain_act;
  assign bus.updatedr  = r_upd_dr & w_chain_act;

endmodule
